// File: rtl/frame_ram_sched.sv
// Shares the single-port 80x60 tile frame RAM between video fetch and queued tile writes.
// Define FRAME_SCHED_COLLISION_EN to build the read-before-write collision check (RD/EV states, coll_* outputs).
module frame_ram_sched #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 4800,
  parameter int QDEPTH     = 4
) (
  input  logic                  px_clk,
  input  logic                  rstn,
  input  logic                  vid_active,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_check,
  output logic                  wr_ready,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  coll_valid,
  output logic [ADDR_WIDTH-1:0] coll_addr,
  output logic [DATA_WIDTH-1:0] coll_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int QPW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0]         Q_FULL   = CW'(QDEPTH);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
`ifdef FRAME_SCHED_COLLISION_EN
    S_RD   = 3'd2,
    S_EV   = 3'd3,
`endif
    S_WR   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] q_addr [QDEPTH];
  logic [DATA_WIDTH-1:0] q_data [QDEPTH];
  logic [QPW-1:0]        q_head, q_tail;
  logic [CW-1:0]         q_count;
  logic                  q_empty;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  clr_step;

  logic [ADDR_WIDTH-1:0] sched_addr;
  logic [DATA_WIDTH-1:0] sched_wdata;
  logic                  sched_we;
  logic                  coll_hit;

`ifdef FRAME_SCHED_COLLISION_EN
  logic                  q_check [QDEPTH];
  logic                  head_check;
  assign head_check = q_check[q_head];
`else
  logic                  unused_wr_check;
  assign unused_wr_check = wr_check;
`endif

  assign wr_ready  = (q_count != Q_FULL);
  assign q_empty   = (q_count == '0);
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign push      = wr_req && (wr_ready || pop);
  assign head_addr = q_addr[q_head];
  assign head_data = q_data[q_head];

  always_ff @(posedge px_clk) begin
    if (push) begin
      q_addr[q_tail] <= wr_addr;
      q_data[q_tail] <= wr_data;
`ifdef FRAME_SCHED_COLLISION_EN
      q_check[q_tail] <= wr_check;
`endif
    end
  end

  always_ff @(posedge px_clk) begin
    if (!rstn) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (push) q_tail <= q_tail + 1'b1;
      if (pop)  q_head <= q_head + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // A new clr_req always restarts the sweep from address 0.
  always_ff @(posedge px_clk) begin
    if (!rstn) begin
      clr_busy <= 1'b0;
      clr_ptr  <= '0;
    end else if (clr_req) begin
      clr_busy <= 1'b1;
      clr_ptr  <= '0;
    end else if (clr_step) begin
      if (clr_ptr == CLR_LAST) begin
        clr_busy <= 1'b0;
        clr_ptr  <= '0;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge px_clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    sched_addr  = clr_ptr;
    sched_wdata = '0;
    sched_we    = 1'b0;
    pop         = 1'b0;
    clr_step    = 1'b0;
    coll_hit    = 1'b0;
    if (vid_active) begin
`ifdef FRAME_SCHED_COLLISION_EN
      // Video stole the port mid-check: drop back and redo the read next blanking.
      if (state == S_RD || state == S_EV) state_nx = S_IDLE;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_busy) begin
            state_nx = S_CLR;
          end else if (!q_empty) begin
`ifdef FRAME_SCHED_COLLISION_EN
            state_nx = head_check ? S_RD : S_WR;
`else
            state_nx = S_WR;
`endif
          end
        end
        S_CLR: begin
          sched_we = 1'b1;
          clr_step = 1'b1;
          if (clr_ptr == CLR_LAST) state_nx = S_IDLE;
        end
`ifdef FRAME_SCHED_COLLISION_EN
        S_RD: begin
          sched_addr = head_addr;
          state_nx   = S_EV;
        end
        S_EV: begin
          sched_addr = head_addr;
          coll_hit   = (ram_rdata != '0);
          state_nx   = S_WR;
        end
`endif
        S_WR: begin
          sched_addr  = head_addr;
          sched_wdata = head_data;
          sched_we    = 1'b1;
          pop         = 1'b1;
          state_nx    = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign vid_data  = ram_rdata;
  assign ram_addr  = vid_active ? vid_addr : sched_addr;
  assign ram_we    = rstn && !vid_active && sched_we;
  assign ram_wdata = sched_wdata;

`ifdef FRAME_SCHED_COLLISION_EN
  assign coll_valid = rstn && coll_hit;
  assign coll_addr  = coll_valid ? head_addr : '0;
  assign coll_data  = coll_valid ? ram_rdata : '0;
`else
  assign coll_valid = 1'b0;
  assign coll_addr  = '0;
  assign coll_data  = '0;
`endif

endmodule

// File: tb/tb_frame_ram_sched.sv
// Scoreboard bench for frame_ram_sched: expected RAM writes and collision reports are queued
// at push time and matched when the DUT drives ram_we / coll_valid.
module tb_frame_ram_sched;

  localparam int AW    = 13;
  localparam int DW    = 3;
  localparam int DEPTH = 4800;
  localparam int QD    = 4;
`ifdef FRAME_SCHED_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic          px_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          vid_active = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_check = 1'b0;
  logic          clr_req = 1'b0;
  logic [DW-1:0] vid_data;
  logic          wr_ready;
  logic          clr_busy;
  logic          coll_valid;
  logic [AW-1:0] coll_addr;
  logic [DW-1:0] coll_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t exp_wr[$];
  ent_t exp_coll[$];

  int total = 0;
  int bad = 0;
  int acc = 0;
  int lost = 0;
  int wr_seen = 0;
  int coll_seen = 0;
  int clr_wr_seen = 0;
  bit mon_en = 1'b0;

  frame_ram_sched #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .QDEPTH(QD)
  ) dut (
    .px_clk(px_clk),
    .rstn(rstn),
    .vid_active(vid_active),
    .vid_addr(vid_addr),
    .vid_data(vid_data),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_check(wr_check),
    .wr_ready(wr_ready),
    .clr_req(clr_req),
    .clr_busy(clr_busy),
    .coll_valid(coll_valid),
    .coll_addr(coll_addr),
    .coll_data(coll_data),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 px_clk = ~px_clk;

  // Frame SRAM with registered read; the preload port lets the bench seed tiles.
  always @(posedge px_clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, expected);
    end
  endtask

  function automatic int pending();
    return acc - wr_seen - lost;
  endfunction

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic preload(input int a, input int d);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_data = DW'(d);
    model_mem[a] = DW'(d);
    tick();
    pre_we = 1'b0;
  endtask

  // Drive one wr_req cycle; if the model says it is accepted, queue its expected effects.
  task automatic applyStimulus(input int a, input int d, input bit chk, input bit will_be_lost);
    bit   exp_ready;
    ent_t e;
    exp_ready = (pending() != QD);
    checkOutput("wr_ready", 32'(wr_ready), 32'(exp_ready));
    wr_req   = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = DW'(d);
    wr_check = chk;
    if (exp_ready) begin
      acc++;
      if (!will_be_lost) begin
        if (COLL_EN && chk && model_mem[a] != '0) begin
          e.addr = AW'(a);
          e.data = model_mem[a];
          exp_coll.push_back(e);
        end
        model_mem[a] = DW'(d);
        e.addr = AW'(a);
        e.data = DW'(d);
        exp_wr.push_back(e);
      end
    end
    tick();
    wr_req   = 1'b0;
    wr_check = 1'b0;
  endtask

  always @(negedge px_clk) begin
    ent_t e;
    if (mon_en) begin
      if (vid_active || !rstn) checkOutput("we_blocked", 32'(ram_we), 32'd0);
      if (vid_active) checkOutput("vid_mux", 32'(ram_addr), 32'(vid_addr));
      if (ram_we) begin
        if (clr_busy) begin
          clr_wr_seen++;
          checkOutput("clr_data", 32'(ram_wdata), 32'd0);
        end else begin
          wr_seen++;
          checkOutput("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checkOutput("wr_addr", 32'(ram_addr), 32'(e.addr));
            checkOutput("wr_data", 32'(ram_wdata), 32'(e.data));
          end
        end
      end
      if (coll_valid) begin
        coll_seen++;
        checkOutput("coll_expected", 32'(exp_coll.size() > 0), 32'd1);
        if (exp_coll.size() > 0) begin
          e = exp_coll.pop_front();
          checkOutput("coll_addr", 32'(coll_addr), 32'(e.addr));
          checkOutput("coll_data", 32'(coll_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, c0, cw0, n, guard, nz;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    mon_en = 1'b1;

    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_clr_busy", 32'(clr_busy), 32'd0);
    checkOutput("rst_coll_valid", 32'(coll_valid), 32'd0);
    checkOutput("rst_coll_addr", 32'(coll_addr), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);

    // Queue three writes during active video, then drain in blanking.
    vid_active = 1'b1;
    vid_addr   = AW'(10);
    applyStimulus(2005, 1, 1'b0, 1'b0);
    applyStimulus(2006, 2, 1'b0, 1'b0);
    applyStimulus(2007, 3, 1'b0, 1'b0);
    checkOutput("active_no_wr", 32'(wr_seen), 32'd0);
    w0 = wr_seen;
    vid_active = 1'b0;
    repeat (6) tick();
    checkOutput("drain_writes", 32'(wr_seen - w0), 32'd3);
    checkOutput("drain_m2005", 32'(mem[2005]), 32'd1);
    checkOutput("drain_m2006", 32'(mem[2006]), 32'd2);
    checkOutput("drain_m2007", 32'(mem[2007]), 32'd3);
    vid_active = 1'b1;
    vid_addr   = AW'(2006);
    tick();
    checkOutput("vid_data", 32'(vid_data), 32'd2);

    // Collision on an occupied tile, then none on an empty one.
    preload(100, 4);
    preload(101, 0);
    vid_active = 1'b0;
    c0 = coll_seen;
    applyStimulus(100, 1, 1'b1, 1'b0);
    repeat (6) tick();
    checkOutput("coll_hit_count", 32'(coll_seen - c0), COLL_EN ? 32'd1 : 32'd0);
    checkOutput("coll_m100", 32'(mem[100]), 32'd1);
    c0 = coll_seen;
    applyStimulus(101, 6, 1'b1, 1'b0);
    repeat (6) tick();
    checkOutput("coll_empty_count", 32'(coll_seen - c0), 32'd0);
    checkOutput("coll_m101", 32'(mem[101]), 32'd6);

    // Video returns during EV: nothing reported or written until the next blank.
    vid_active = 1'b1;
    preload(300, 5);
    vid_active = 1'b0;
    c0 = coll_seen;
    w0 = wr_seen;
    applyStimulus(300, 2, 1'b1, 1'b0);
    tick();
    tick();
    vid_active = 1'b1;
    repeat (5) tick();
    checkOutput("abort_coll", 32'(coll_seen - c0), 32'd0);
    checkOutput("abort_wr", 32'(wr_seen - w0), COLL_EN ? 32'd0 : 32'd1);
    vid_active = 1'b0;
    repeat (8) tick();
    checkOutput("redo_coll", 32'(coll_seen - c0), COLL_EN ? 32'd1 : 32'd0);
    checkOutput("redo_wr", 32'(wr_seen - w0), 32'd1);
    checkOutput("redo_m300", 32'(mem[300]), 32'd2);

    // Five pushes into a four-deep queue: the fifth is dropped.
    vid_active = 1'b1;
    w0 = wr_seen;
    for (int i = 0; i < 5; i++) applyStimulus(600 + i, i + 1, 1'b0, 1'b0);
    checkOutput("full_ready", 32'(wr_ready), 32'd0);
    vid_active = 1'b0;
    repeat (12) tick();
    checkOutput("full_writes", 32'(wr_seen - w0), 32'd4);
    checkOutput("full_ready_after", 32'(wr_ready), 32'd1);

    // Full-frame clear with a write queued mid-sweep.
    clr_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    tick();
    clr_req = 1'b0;
    cw0 = clr_wr_seen;
    n = 0;
    guard = 0;
    while (clr_busy && guard < 6000) begin
      if (n == 100) applyStimulus(50, 2, 1'b0, 1'b0);
      else tick();
      n++;
      guard++;
    end
    checkOutput("clr_len_ok", 32'(n >= DEPTH && n <= DEPTH + 1), 32'd1);
    checkOutput("clr_writes", 32'(clr_wr_seen - cw0), 32'(DEPTH));
    repeat (4) tick();
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (i != 50 && mem[i] != '0) nz++;
    checkOutput("clr_nonzero", 32'(nz), 32'd0);
    checkOutput("clr_m50", 32'(mem[50]), 32'd2);

    // Random mix of blanking, checked and unchecked writes on a few tiles.
    vid_active = 1'b1;
    for (int i = 0; i < 4; i++) preload(400 + i, int'($urandom_range(0, 7)));
    for (int i = 0; i < 200; i++) begin
      vid_active = ($urandom_range(0, 3) == 0);
      if (pending() < QD - 1 && $urandom_range(0, 1) == 1)
        applyStimulus(400 + int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'b0);
      else
        tick();
    end
    vid_active = 1'b0;
    repeat (40) tick();
    for (int i = 0; i < 4; i++) checkOutput("rand_mem", 32'(mem[400 + i]), 32'(model_mem[400 + i]));
    checkOutput("rand_wr_left", 32'(exp_wr.size()), 32'd0);
    checkOutput("rand_coll_left", 32'(exp_coll.size()), 32'd0);

    // Reset mid-clear with two queued writes: everything in flight is discarded.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (50) tick();
    vid_active = 1'b1;
    applyStimulus(700, 1, 1'b0, 1'b1);
    applyStimulus(701, 2, 1'b0, 1'b1);
    checkOutput("pre_rst_busy", 32'(clr_busy), 32'd1);
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    lost = acc - wr_seen;
    checkOutput("rst2_clr_busy", 32'(clr_busy), 32'd0);
    checkOutput("rst2_wr_ready", 32'(wr_ready), 32'd1);
    w0  = wr_seen;
    cw0 = clr_wr_seen;
    vid_active = 1'b0;
    repeat (20) tick();
    checkOutput("rst2_no_wr", 32'(wr_seen - w0), 32'd0);
    checkOutput("rst2_no_clr", 32'(clr_wr_seen - cw0), 32'd0);
    checkOutput("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    checkOutput("sb_coll_empty", 32'(exp_coll.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
